// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: drains the debug-UART transmit FIFO onto the TX pin as 8N1.
// Define UART_FIFO_TX_PARITY_EN to insert an even parity bit before stop.
module uart_fifo_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       CLK_I,
    input  logic       RST_NI,
    input  logic       TX_EN_I,
    input  logic       FIFO_EMPTY_I,
    input  logic [7:0] FIFO_DATA_I,
    output logic       FIFO_RE_O,
    output logic       TX_O,
    output logic       BUSY_O,
    output logic       TX_DONE_O
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_FIFO_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;
`endif

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic          bit_end;
    logic          pop;
`ifdef UART_FIFO_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    assign bit_end = (cnt_q == CNT_LAST);

    // A new frame may start from idle or on the very last stop-bit cycle.
    assign pop = RST_NI & TX_EN_I & ~FIFO_EMPTY_I &
                 ((state_q == S_IDLE) |
                  ((state_q == S_STOP) & bit_end));

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        idx_d   = idx_q;
        shift_d = shift_q;
        done_d  = (state_q == S_STOP) & bit_end;
        tx_d    = 1'b1;
`ifdef UART_FIFO_TX_PARITY_EN
        par_d   = par_q;
`endif

        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_FIFO_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_FIFO_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (pop) begin
            state_d = S_START;
            cnt_d   = '0;
            idx_d   = 3'd0;
            shift_d = FIFO_DATA_I;
`ifdef UART_FIFO_TX_PARITY_EN
            par_d   = ^FIFO_DATA_I;
`endif
        end

        // The line register is loaded with the level of the state being entered.
        unique case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
`ifdef UART_FIFO_TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

`ifdef UART_FIFO_TX_PARITY_EN
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    assign FIFO_RE_O = pop;
    assign TX_O      = tx_q;
    assign BUSY_O    = (state_q != S_IDLE);
    assign TX_DONE_O = done_q;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// tb_uart_fifo_tx: table vectors, directed corner sequences and random
// traffic checked against a frame-timing model of the transmitter.
module tb_uart_fifo_tx;

    localparam int CPB = 4;
`ifdef UART_FIFO_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * CPB;

    typedef struct {
        logic [7:0] d;
        logic [9:0] frame;
        logic       par;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_en = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       re, tx, busy, done;

    logic [7:0] q[$];
    int         re_log[$];
    int         done_log[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic       re_s = 1'b0;

    int          last_pop = -1000;
    int          prev_pop = -1000;
    logic [10:0] cur_frame = '1;

    vec_t tbl[7];

    uart_fifo_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .CLK_I       (clk),
        .RST_NI      (rst_n),
        .TX_EN_I     (tx_en),
        .FIFO_EMPTY_I(fifo_empty),
        .FIFO_DATA_I (fifo_data),
        .FIFO_RE_O   (re),
        .TX_O        (tx),
        .BUSY_O      (busy),
        .TX_DONE_O   (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [10:0] mkframe(input logic [7:0] d);
`ifdef UART_FIFO_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {2'b11, d, 1'b0};
`endif
    endfunction

    task automatic sync();
        fifo_empty = (q.size() == 0);
        fifo_data  = fifo_empty ? 8'h00 : q[0];
    endtask

    task automatic push(input logic [7:0] d);
        q.push_back(d);
        sync();
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (re_s && q.size() > 0) q.delete(0);
        sync();
    endtask

    // Model: a frame lasts FL cycles after its pop; the next pop may
    // happen on its last cycle; done pulses one cycle after each frame.
    always @(negedge clk) begin
        logic e_re, e_tx, e_busy, e_done;
        int   k;
        if (!rst_n) begin
            last_pop = -1000;
            prev_pop = -1000;
            e_re     = 1'b0;
            e_tx     = 1'b1;
            e_busy   = 1'b0;
            e_done   = 1'b0;
        end else begin
            e_re   = tx_en && !fifo_empty && (cyc >= last_pop + FL);
            k      = cyc - last_pop - 1;
            e_busy = (k >= 0) && (k < FL);
            e_tx   = e_busy ? cur_frame[k / CPB] : 1'b1;
            e_done = (cyc == last_pop + FL + 1) ||
                     (cyc == prev_pop + FL + 1);
        end
        chk("m_re", 32'(re), 32'(e_re));
        chk("m_tx", 32'(tx), 32'(e_tx));
        chk("m_busy", 32'(busy), 32'(e_busy));
        chk("m_done", 32'(done), 32'(e_done));
        if (re) re_log.push_back(cyc);
        if (done) done_log.push_back(cyc);
        if (e_re) begin
            prev_pop  = last_pop;
            last_pop  = cyc;
            cur_frame = mkframe(fifo_data);
        end
        re_s = re;
    end

    task automatic run_vec(input vec_t v);
        logic e;
        cycle();
        push(v.d);
        @(negedge clk);
        chk("tbl_re", 32'(re), 32'd1);
        for (int b = 0; b < NB; b++) begin
            if (b < 9) e = v.frame[b];
`ifdef UART_FIFO_TX_PARITY_EN
            else if (b == 9) e = v.par;
`endif
            else e = 1'b1;
            for (int j = 0; j < CPB; j++) begin
                cycle();
                @(negedge clk);
                chk("tbl_tx", 32'(tx), 32'(e));
            end
        end
        cycle();
        @(negedge clk);
        chk("tbl_done", 32'(done), 32'd1);
        chk("tbl_busy", 32'(busy), 32'd0);
        cycle();
        @(negedge clk);
        chk("tbl_done_end", 32'(done), 32'd0);
    endtask

    initial begin
        int t0, t1;
        tbl[0] = '{8'hA5, 10'h34A, 1'b0};
        tbl[1] = '{8'h00, 10'h200, 1'b0};
        tbl[2] = '{8'hFF, 10'h3FE, 1'b0};
        tbl[3] = '{8'h3C, 10'h278, 1'b0};
        tbl[4] = '{8'h81, 10'h302, 1'b0};
        tbl[5] = '{8'h07, 10'h20E, 1'b1};
        tbl[6] = '{8'h01, 10'h202, 1'b1};

        sync();
        repeat (3) cycle();
        @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        cycle();
        rst_n = 1'b1;
        tx_en = 1'b1;
        repeat (3) cycle();

        foreach (tbl[i]) run_vec(tbl[i]);

        // Reset while a zero data bit is on the line.
        cycle();
        push(8'h00);
        repeat (10) cycle();
        @(negedge clk);
        chk("mid_tx_low", 32'(tx), 32'd0);
        cycle();
        rst_n = 1'b0;
        #1;
        chk("async_tx", 32'(tx), 32'd1);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_re", 32'(re), 32'd0);
        repeat (2) cycle();
        rst_n = 1'b1;
        re_log.delete();
        repeat (20) cycle();
        @(negedge clk);
        chk("post_rst_nopop", 32'(re_log.size()), 32'd0);
        chk("post_rst_tx", 32'(tx), 32'd1);

        // Back-to-back frames.
        cycle();
        re_log.delete();
        done_log.delete();
        push(8'h00);
        push(8'hFF);
        t0 = cyc;
        repeat (2 * FL + 10) cycle();
        @(negedge clk);
        chk("b2b_npop", 32'(re_log.size()), 32'd2);
        chk("b2b_ndone", 32'(done_log.size()), 32'd2);
        if (re_log.size() >= 2) begin
            chk("b2b_first", 32'(re_log[0]), 32'(t0));
            chk("b2b_gap", 32'(re_log[1] - re_log[0]), 32'(FL));
        end
        if (done_log.size() >= 2) begin
            chk("b2b_done0", 32'(done_log[0]), 32'(t0 + FL + 1));
            chk("b2b_dgap", 32'(done_log[1] - done_log[0]), 32'(FL));
        end

        // Enable dropped mid-frame with bytes queued.
        cycle();
        re_log.delete();
        done_log.delete();
        push(8'h11);
        push(8'h22);
        push(8'h33);
        t0 = cyc;
        repeat (10) cycle();
        tx_en = 1'b0;
        repeat (60) cycle();
        @(negedge clk);
        chk("gate_npop", 32'(re_log.size()), 32'd1);
        chk("gate_empty", 32'(fifo_empty), 32'd0);
        chk("gate_ndone", 32'(done_log.size()), 32'd1);
        if (done_log.size() >= 1) begin
            chk("gate_done_at", 32'(done_log[0]), 32'(t0 + FL + 1));
        end
        cycle();
        tx_en = 1'b1;
        t1 = cyc;
        @(negedge clk);
        chk("gate_resume", 32'(re), 32'd1);
        repeat (2 * FL + 10) cycle();
        @(negedge clk);
        chk("gate_drained", 32'(fifo_empty), 32'd1);
        chk("gate_resume_at", 32'(re_log[1]), 32'(t1));

        // Byte arrives in the first idle cycle after a stop bit.
        cycle();
        re_log.delete();
        push(8'h3C);
        t0 = cyc;
        repeat (FL + 1) cycle();
        push(8'hC3);
        @(negedge clk);
        chk("eb_pop", 32'(re), 32'd1);
        repeat (FL + 5) cycle();
        @(negedge clk);
        chk("eb_npop", 32'(re_log.size()), 32'd2);
        if (re_log.size() >= 2) begin
            chk("eb_gap", 32'(re_log[1] - re_log[0]), 32'(FL + 1));
        end

        // Random traffic, enable toggling and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cycle();
            rst_n = ($urandom_range(0, 399) != 0);
            tx_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 29) == 0 && q.size() < 8) begin
                push(8'($urandom));
            end
        end

        rst_n = 1'b1;
        tx_en = 1'b1;
        repeat (12 * FL) cycle();
        @(negedge clk);
        chk("final_empty", 32'(fifo_empty), 32'd1);
        chk("final_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
